register_write_arbiter: RTL and testbench
=========================================

# register_write_arbiter

Shares the general-purpose register file's single write port among N write-back requesters: the main pipeline write-back, the multiply/divide unit and the memory load-return path. The block round-robin arbitrates valid requests with a valid/ready handshake. It drives a registered `write_enable`/`write_address`/`write_data` triple straight into the register file, and flags read-after-write hazards for the decode-stage read ports. It sits between the write-back sources and the register file.

## Interface
- `REQUESTERS`, default 3: number of write requesters (2..8); index 0 is the pipeline write-back.
- `clock`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low; `reset == 0` at a rising edge clears all state.
- `write_hold`  input  1  pipeline stall; while 1, no request is granted.
- `request_valid`  input  REQUESTERS  per-requester write request.
- `request_ready`  output  REQUESTERS  one-hot grant; a write is accepted when valid and ready are both 1.
- `request_address`  input  5*REQUESTERS  destination register; requester i at bits [5i+4:5i].
- `request_data`  input  32*REQUESTERS  write data; requester i at bits [32i+31:32i].
- `write_enable`  output  1  to register file write port.
- `write_address`  output  5  to register file.
- `write_data`  output  32  to register file.
- `read_address_a`, `read_address_b`  input  5 each  decode-stage read addresses.
- `hazard_a`, `hazard_b`  output  1 each  a valid, not-yet-accepted request targets that nonzero address.

## Operation
- Priority pointer `next` (log2 REQUESTERS bits): the highest-priority index. Search order is `next`, `next+1`, … modulo REQUESTERS.
- Grant: `request_ready` = one-hot of the first valid requester in search order. It is all-zero when `write_hold == 1`, when no request is valid, or while `reset == 0`.
- The grant is combinational from `request_valid`, `next` and `write_hold`. It never depends on `request_ready` (no loop).
- On acceptance by requester g: `next <= (g+1) mod REQUESTERS`. Without an acceptance, `next` holds.
- Output stage on acceptance: `write_address <= request_address[g]` and `write_data <= request_data[g]`. `write_enable <= 1` only if that address is nonzero.
- Address-0 requests are still accepted (ready asserted, pointer advances) but produce `write_enable = 0`.
- Without an acceptance: `write_enable <= 0`. Address and data hold their previous values.
- Hazard outputs: `hazard_x = (read_address_x != 0) && OR over i of (request_valid[i] && request_address[i] == read_address_x)`. These are combinational.
- The output stage is not counted as a hazard: the register file commits its write on the falling edge of that same cycle.
- Requesters must hold valid, address and data stable until accepted. The block does not check this.
- Reset (`reset == 0` at a rising edge): `next = 0`, `write_enable = 0`, `write_address = 0`, `write_data = 0`. A request pending at reset is dropped; the requester must re-present it.

## Timing
- Latency: acceptance at edge k puts `write_enable` high for exactly the cycle after edge k. The register file commits on the following falling edge.
- Throughput: one accepted write per cycle with no bubbles. Back-to-back grants to the same requester occur only when no other requester is valid.
- Fairness: a continuously valid requester is granted within REQUESTERS cycles while `write_hold` stays 0.
- `write_hold` is asserted/deasserted combinationally. A hold in cycle k blocks acceptance at edge k; `write_enable` is then 0 in cycle k+1.
- Simultaneous requests to the same address from two requesters are serialized in grant order. The later grant wins in the register file.
- Reset overrides everything. In the cycle `reset` is low, `request_ready` is 0.

## Structure
- Shared defines header: `RESET_ENABLE` (now `1'b0`), `RESET_DISABLE`, `WRITE_ENABLE`, `WRITE_DISABLE`, register address width (5), data width (32), register count.
- The one-hot round-robin grant logic goes in a natural sub-module, `round_robin_arbiter` (parameter WIDTH; inputs request vector, pointer, enable; output one-hot grant), reusable elsewhere.
- The top level holds the pointer register, the output register stage, the flattened-bus muxing and the hazard comparators.

## Test plan
- Reset: hold `reset = 0` with all requests valid → `request_ready = 000` and all write outputs 0. Release → the first grant goes to index 0.
- Single requester: requester 1 presents addr 5, data 0xDEADBEEF → ready[1] in the same cycle; next cycle `write_enable = 1`, addr 5, data 0xDEADBEEF; register 5 reads back 0xDEADBEEF.
- Round-robin: all three valid continuously for 6 cycles → grant sequence 0,1,2,0,1,2 and `write_enable` high in 6 consecutive cycles.
- Address zero: requester 2 writes addr 0, data 0x1234 → accepted, pointer advances, `write_enable = 0`, register 0 still reads 0.
- Hold and hazard: `write_hold = 1` with requester 0 valid at addr 7 and `read_address_a = 7` → ready 0 and `hazard_a = 1`, with `hazard_a = 0` for read address 0. Release hold → accepted; `hazard_a` drops once valid deasserts.
- Reset mid-operation: assert `reset = 0` the cycle after an acceptance → `write_enable` cleared at that edge, `next = 0`, and the held request is not written.

Source files
------------

// File: rtl/register_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter.
//   RESET_ENABLE / RESET_DISABLE : level of the active-low reset input
//   WRITE_ENABLE / WRITE_DISABLE : level driven on the register-file write strobe
//   ADDR_WIDTH, DATA_WIDTH, REG_COUNT : general-purpose register file geometry
package register_write_arbiter_pkg;

   localparam logic RESET_ENABLE  = 1'b0;
   localparam logic RESET_DISABLE = 1'b1;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   localparam int ADDR_WIDTH = 5;
   localparam int DATA_WIDTH = 32;
   localparam int REG_COUNT  = 32;

endpackage

// File: rtl/round_robin_arbiter.sv
// One-hot round-robin grant, purely combinational.
//   request [WIDTH-1:0]     : request vector
//   pointer [PTR_WIDTH-1:0] : highest-priority index; search runs pointer, pointer+1, ... mod WIDTH
//   enable                  : when 0 the grant is forced to all-zero
//   grant   [WIDTH-1:0]     : one-hot of the first requesting index in search order
module round_robin_arbiter #(
   parameter int WIDTH     = 3,
   parameter int PTR_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]     request,
   input  logic [PTR_WIDTH-1:0] pointer,
   input  logic                 enable,
   output logic [WIDTH-1:0]     grant
);

   logic                 found;
   logic [PTR_WIDTH-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int off = 0; off < WIDTH; off++) begin
         idx = PTR_WIDTH'((int'(pointer) + off) % WIDTH);
         if (enable && !found && request[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/register_write_arbiter.sv
// Shares the register file's single write port among REQUESTERS write-back sources
// (index 0 = pipeline write-back) and flags read-after-write hazards for decode.
//   clock, reset (sync, active-low), write_hold (stall: no grant while 1)
//   request_valid/ready : per-requester handshake, ready is a one-hot grant
//   request_address/data: flattened buses, requester i at [5i+4:5i] / [32i+31:32i]
//   write_enable/address/data : registered register-file write port
//   read_address_a/b -> hazard_a/b : pending nonzero-address write to that register
module register_write_arbiter
   import register_write_arbiter_pkg::*;
#(
   parameter int REQUESTERS = 3
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             write_hold,
   input  logic [REQUESTERS-1:0]            request_valid,
   output logic [REQUESTERS-1:0]            request_ready,
   input  logic [ADDR_WIDTH*REQUESTERS-1:0] request_address,
   input  logic [DATA_WIDTH*REQUESTERS-1:0] request_data,
   output logic                             write_enable,
   output logic [ADDR_WIDTH-1:0]            write_address,
   output logic [DATA_WIDTH-1:0]            write_data,
   input  logic [ADDR_WIDTH-1:0]            read_address_a,
   input  logic [ADDR_WIDTH-1:0]            read_address_b,
   output logic                             hazard_a,
   output logic                             hazard_b
);

   localparam int PTR_WIDTH = $clog2(REQUESTERS);

   logic [PTR_WIDTH-1:0]  rr_next;
   logic [PTR_WIDTH-1:0]  grant_index;
   logic [REQUESTERS-1:0] grant;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_address;
   logic [DATA_WIDTH-1:0] sel_data;

   // Reset gates the grant combinationally so nothing is handshaken in a reset cycle.
   round_robin_arbiter #(
      .WIDTH     (REQUESTERS),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_arbiter (
      .request (request_valid),
      .pointer (rr_next),
      .enable  (!write_hold && (reset == RESET_DISABLE)),
      .grant   (grant)
   );

   assign request_ready = grant;
   assign accept        = |(grant & request_valid);

   always_comb begin
      grant_index = '0;
      sel_address = '0;
      sel_data    = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (grant[i]) begin
            grant_index = PTR_WIDTH'(i);
            sel_address = request_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data    = request_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // The output stage is not a hazard source: the register file commits it on the
   // falling edge of the same cycle, before decode samples its read ports.
   always_comb begin
      hazard_a = 1'b0;
      hazard_b = 1'b0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (request_valid[i] &&
             request_address[i*ADDR_WIDTH +: ADDR_WIDTH] == read_address_a)
            hazard_a = 1'b1;
         if (request_valid[i] &&
             request_address[i*ADDR_WIDTH +: ADDR_WIDTH] == read_address_b)
            hazard_b = 1'b1;
      end
      if (read_address_a == '0) hazard_a = 1'b0;
      if (read_address_b == '0) hazard_b = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
         rr_next       <= '0;
         write_enable  <= WRITE_DISABLE;
         write_address <= '0;
         write_data    <= '0;
      end else if (accept) begin
         rr_next       <= (grant_index == PTR_WIDTH'(REQUESTERS - 1)) ? '0 : grant_index + 1'b1;
         // Address-0 writes complete the handshake but never strobe the register file.
         write_enable  <= (sel_address != '0) ? WRITE_ENABLE : WRITE_DISABLE;
         write_address <= sel_address;
         write_data    <= sel_data;
      end else begin
         write_enable  <= WRITE_DISABLE;
      end
   end

endmodule

// File: tb/tb_register_write_arbiter.sv
module tb_register_write_arbiter;

   localparam int N = 3;

   logic          clock;
   logic          reset;
   logic          write_hold;
   logic [N-1:0]  request_valid;
   logic [N-1:0]  request_ready;
   logic [5*N-1:0]  request_address;
   logic [32*N-1:0] request_data;
   logic          write_enable;
   logic [4:0]    write_address;
   logic [31:0]   write_data;
   logic [4:0]    read_address_a;
   logic [4:0]    read_address_b;
   logic          hazard_a;
   logic          hazard_b;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_next;
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   int          last_grant;
   logic        last_reset_low;
   int          wait_cnt [N];

   register_write_arbiter #(.REQUESTERS(N)) dut (
      .clock           (clock),
      .reset           (reset),
      .write_hold      (write_hold),
      .request_valid   (request_valid),
      .request_ready   (request_ready),
      .request_address (request_address),
      .request_data    (request_data),
      .write_enable    (write_enable),
      .write_address   (write_address),
      .write_data      (write_data),
      .read_address_a  (read_address_a),
      .read_address_b  (read_address_b),
      .hazard_a        (hazard_a),
      .hazard_b        (hazard_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [4:0] addr_of(input int i);
      logic [5*N-1:0] a;
      a = request_address;
      return a[i*5 +: 5];
   endfunction

   function automatic logic [31:0] data_of(input int i);
      logic [32*N-1:0] d;
      d = request_data;
      return d[i*32 +: 32];
   endfunction

   // first valid requester starting from the priority pointer, -1 if none may be granted
   function automatic int model_grant();
      if (!reset || write_hold) return -1;
      for (int k = 0; k < N; k++)
         if (request_valid[(m_next + k) % N]) return (m_next + k) % N;
      return -1;
   endfunction

   function automatic logic model_hazard(input logic [4:0] ra);
      if (ra == 5'd0) return 1'b0;
      for (int i = 0; i < N; i++)
         if (request_valid[i] && addr_of(i) == ra) return 1'b1;
      return 1'b0;
   endfunction

   // Entered just after a rising edge with inputs already driven; leaves 1 time unit
   // after the next rising edge.
   task automatic step();
      int g;
      @(negedge clock);
      g = model_grant();
      check_val("ready",    32'(request_ready), (g < 0) ? 32'd0 : 32'(1 << g));
      check_val("hazard_a", 32'(hazard_a), 32'(model_hazard(read_address_a)));
      check_val("hazard_b", 32'(hazard_b), 32'(model_hazard(read_address_b)));
      check_val("wr_en",    32'(write_enable), 32'(m_we));
      check_val("wr_addr",  32'(write_address), 32'(m_wa));
      check_val("wr_data",  write_data, m_wd);
      @(posedge clock);
      last_reset_low = !reset;
      if (!reset) begin
         m_next = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
      end else if (g >= 0) begin
         m_we   = (addr_of(g) != 5'd0);
         m_wa   = addr_of(g);
         m_wd   = data_of(g);
         m_next = (g + 1) % N;
      end else begin
         m_we = 1'b0;
      end
      last_grant = g;
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
      request_valid[i] = v;
      request_address[i*5 +: 5] = a;
      request_data[i*32 +: 32]  = d;
   endtask

   initial begin
      m_next = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
      last_grant = -1; last_reset_low = 1'b1;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      reset = 1'b0; write_hold = 1'b0;
      request_valid = '0; request_address = '0; request_data = '0;
      read_address_a = '0; read_address_b = '0;
      @(posedge clock); #1;

      // reset with all requests valid: no grant, outputs cleared
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
      step();
      step();
      check_val("rst_ready", 32'(request_ready), 32'd0);
      check_val("rst_we", 32'(write_enable), 32'd0);

      // release: grant sequence 0,1,2,0,1,2 with write strobes every cycle
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check_val("rr_seq", 32'(last_grant), 32'(k % N));
         check_val("rr_we", 32'(write_enable), 32'd1);
      end

      // single requester 1 (pointer is back at 0)
      request_valid = '0;
      set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
      step();
      check_val("single_grant", 32'(last_grant), 32'd1);
      check_val("single_we", 32'(write_enable), 32'd1);
      check_val("single_addr", 32'(write_address), 32'd5);
      check_val("single_data", write_data, 32'hDEADBEEF);

      // address zero from requester 2: accepted, no strobe, pointer advances to 0
      request_valid = '0;
      set_req(2, 1'b1, 5'd0, 32'h1234);
      step();
      check_val("a0_grant", 32'(last_grant), 32'd2);
      check_val("a0_we", 32'(write_enable), 32'd0);
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'd10 + 5'(i), 32'h55 + 32'(i));
      step();
      check_val("a0_ptr", 32'(last_grant), 32'd0);

      // hold with a hazard
      request_valid = '0;
      write_hold = 1'b1;
      set_req(0, 1'b1, 5'd7, 32'h77);
      read_address_a = 5'd7;
      step();
      check_val("hold_ready", 32'(request_ready), 32'd0);
      check_val("hold_haz", 32'(hazard_a), 32'd1);
      check_val("hold_we", 32'(write_enable), 32'd0);
      read_address_a = 5'd0;
      #1 check_val("haz_zero", 32'(hazard_a), 32'd0);
      read_address_a = 5'd7;
      write_hold = 1'b0;
      step();
      check_val("unhold_grant", 32'(last_grant), 32'd0);
      request_valid = '0;
      #1 check_val("haz_drop", 32'(hazard_a), 32'd0);

      // reset the cycle after an acceptance
      set_req(1, 1'b1, 5'd9, 32'hCAFE0009);
      step();
      check_val("mid_acc", 32'(last_grant), 32'd1);
      request_valid = '0;
      set_req(2, 1'b1, 5'd11, 32'hBAD0000B);
      reset = 1'b0;
      step();
      check_val("mid_rst_we", 32'(write_enable), 32'd0);
      check_val("mid_rst_addr", 32'(write_address), 32'd0);
      request_valid = '0;
      reset = 1'b1;
      step();
      check_val("mid_dropped", 32'(write_enable), 32'd0);

      // randomized traffic; requests are held until accepted
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (last_reset_low) request_valid = '0;
         else if (last_grant >= 0) request_valid[last_grant] = 1'b0;
         for (int i = 0; i < N; i++)
            if (!request_valid[i] && $urandom_range(0, 2) != 0)
               set_req(i, 1'b1, 5'($urandom_range(0, 7)), $urandom);
         write_hold     = ($urandom_range(0, 4) == 0);
         reset          = ($urandom_range(0, 60) != 0);
         read_address_a = 5'($urandom_range(0, 7));
         read_address_b = 5'($urandom_range(0, 7));
         step();
         // fairness: waits counted only across unheld, out-of-reset cycles
         for (int i = 0; i < N; i++) begin
            if (!reset || write_hold || !request_valid[i]) wait_cnt[i] = 0;
            else if (last_grant == i) begin
               check_val("fair", 32'(wait_cnt[i] < N), 32'd1);
               wait_cnt[i] = 0;
            end else wait_cnt[i]++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
